// File: rtl/conv_pass_sequencer_if.sv
// Handshake/bus bundle between the CONV pass sequencer and the MAC datapath /
// layer-memory port. The sequencer uses the master view.
interface conv_pass_sequencer_if #(
  parameter int IMG_LOG2 = 6
);
  localparam int AW = 2 * IMG_LOG2;

  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic          tap_valid;
  logic [3:0]    tap_idx;
  logic          tap_pad;
  logic          acc_clr;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic          pool_first;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic          wr_ack;
  logic [2:0]    csel;

  modport master (
    input  ready, wr_ack,
    output busy, iaddr, tap_valid, tap_idx, tap_pad, acc_clr,
           crd, caddr_rd, pool_first, wr_req, wr_addr, csel
  );

  modport slave (
    output ready, wr_ack,
    input  busy, iaddr, tap_valid, tap_idx, tap_pad, acc_clr,
           crd, caddr_rd, pool_first, wr_req, wr_addr, csel
  );
endinterface

// File: rtl/conv_pass_sequencer.sv
// Control sequencer for the CONV pass: 3x3 zero-padded conv into layer 0, then
// 2x2 max-pool into layer 1. Pooling phase is present only with SEQ_POOL_EN.
module conv_pass_sequencer #(
  parameter int PIPE_LAT = 2,
  parameter int IMG_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  conv_pass_sequencer_if.master bus
);
  localparam int AW = 2 * IMG_LOG2;
  localparam int CW = $clog2(PIPE_LAT + 1) + 1;

  typedef enum logic [2:0] {
    IDLE, TAP, CDRAIN, CWR,
`ifdef SEQ_POOL_EN
    PRD, PDRAIN, PWR,
`endif
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pix_q, pix_d;
  logic [3:0]    tap_q, tap_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef SEQ_POOL_EN
  localparam int QW = 2 * (IMG_LOG2 - 1);
  logic [QW-1:0] q_q, q_d;
  logic [1:0]    rd_q, rd_d;
`endif

  // Tap offsets: one extra top bit on row/col flags both -1 and IMG side.
  logic [1:0]          tr;
  logic [3:0]          tc;
  logic [IMG_LOG2:0]   row_e, col_e;
  logic                pad;
  always_comb begin
    tr    = (tap_q >= 4'd6) ? 2'd2 : (tap_q >= 4'd3) ? 2'd1 : 2'd0;
    tc    = tap_q - ({2'b00, tr} << 1) - {2'b00, tr};
    row_e = {1'b0, pix_q[AW-1:IMG_LOG2]} + (IMG_LOG2+1)'(tr) - (IMG_LOG2+1)'(1);
    col_e = {1'b0, pix_q[IMG_LOG2-1:0]} + (IMG_LOG2+1)'(tc[1:0]) - (IMG_LOG2+1)'(1);
    pad   = row_e[IMG_LOG2] | col_e[IMG_LOG2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pix_q   <= '0;
      tap_q   <= '0;
      cnt_q   <= '0;
`ifdef SEQ_POOL_EN
      q_q     <= '0;
      rd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      tap_q   <= tap_d;
      cnt_q   <= cnt_d;
`ifdef SEQ_POOL_EN
      q_q     <= q_d;
      rd_q    <= rd_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    tap_d   = tap_q;
    cnt_d   = cnt_q;
`ifdef SEQ_POOL_EN
    q_d     = q_q;
    rd_d    = rd_q;
`endif
    unique case (state_q)
      IDLE: if (bus.ready) begin
        state_d = TAP;
        pix_d   = '0;
        tap_d   = '0;
      end
      TAP: begin
        tap_d = tap_q + 4'd1;
        if (tap_q == 4'd8) begin
          state_d = CDRAIN;
          tap_d   = '0;
          cnt_d   = '0;
        end
      end
      CDRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(PIPE_LAT - 1)) state_d = CWR;
      end
      CWR: if (bus.wr_ack) begin
        if (&pix_q) begin
`ifdef SEQ_POOL_EN
          state_d = PRD;
          q_d     = '0;
          rd_d    = '0;
`else
          state_d = DONE;
`endif
        end else begin
          pix_d   = pix_q + AW'(1);
          state_d = TAP;
        end
      end
`ifdef SEQ_POOL_EN
      PRD: begin
        rd_d = rd_q + 2'd1;
        if (rd_q == 2'd3) begin
          state_d = PDRAIN;
          cnt_d   = '0;
        end
      end
      // Read data lands a cycle after crd, hence one extra drain cycle.
      PDRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(PIPE_LAT)) state_d = PWR;
      end
      PWR: if (bus.wr_ack) begin
        if (&q_q) state_d = DONE;
        else begin
          q_d     = q_q + QW'(1);
          rd_d    = '0;
          state_d = PRD;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state_q != IDLE) && (state_q != DONE);
    bus.iaddr      = '0;
    bus.tap_valid  = 1'b0;
    bus.tap_idx    = '0;
    bus.tap_pad    = 1'b0;
    bus.acc_clr    = 1'b0;
    bus.crd        = 1'b0;
    bus.caddr_rd   = '0;
    bus.pool_first = 1'b0;
    bus.wr_req     = 1'b0;
    bus.wr_addr    = '0;
    bus.csel       = 3'b000;
    unique case (state_q)
      TAP: begin
        bus.tap_valid = 1'b1;
        bus.tap_idx   = tap_q;
        bus.tap_pad   = pad;
        bus.acc_clr   = (tap_q == 4'd0);
        bus.iaddr     = pad ? '0 : {row_e[IMG_LOG2-1:0], col_e[IMG_LOG2-1:0]};
      end
      CWR: begin
        bus.wr_req  = 1'b1;
        bus.wr_addr = pix_q;
        bus.csel    = 3'b001;
      end
`ifdef SEQ_POOL_EN
      PRD: begin
        bus.crd        = 1'b1;
        bus.csel       = 3'b001;
        bus.pool_first = (rd_q == 2'd0);
        bus.caddr_rd   = {q_q[QW-1:IMG_LOG2-1], rd_q[1], q_q[IMG_LOG2-2:0], rd_q[0]};
      end
      PWR: begin
        bus.wr_req  = 1'b1;
        bus.wr_addr = AW'(q_q);
        bus.csel    = 3'b011;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_conv_pass_sequencer.sv
// Bench for conv_pass_sequencer: slot-timed reference model, random write-ack
// latency and random ack noise, full pass, mid-run ready and mid-run reset.
module tb_conv_pass_sequencer;
  localparam int PL = 2;
`ifdef SEQ_POOL_EN
  localparam bit POOL = 1'b1;
`else
  localparam bit POOL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv_pass_sequencer_if s ();
  conv_pass_sequencer #(.PIPE_LAT(PL), .IMG_LOG2(6)) dut (.clk(clk), .reset(reset), .bus(s));

  int checks = 0;
  int errors = 0;
  // Reference model: t = cycles into the current pixel/pool slot.
  bit running = 0, pool_ph = 0, in_done = 0;
  int t = 0, pix = 0, q = 0, wtarget = 0, nconv = 0, npool = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"}, s.busy, 0);
    chk({pfx, "_tapv"}, s.tap_valid, 0);
    chk({pfx, "_idx"}, s.tap_idx, 0);
    chk({pfx, "_pad"}, s.tap_pad, 0);
    chk({pfx, "_iaddr"}, s.iaddr, 0);
    chk({pfx, "_accclr"}, s.acc_clr, 0);
    chk({pfx, "_crd"}, s.crd, 0);
    chk({pfx, "_caddr"}, s.caddr_rd, 0);
    chk({pfx, "_pfirst"}, s.pool_first, 0);
    chk({pfx, "_wrreq"}, s.wr_req, 0);
    chk({pfx, "_wraddr"}, s.wr_addr, 0);
    chk({pfx, "_csel"}, s.csel, 0);
  endtask

  task automatic cyc(input bit rdy);
    bit exp_tap, exp_rd, exp_req, acked, start, pad;
    int reqt, r, c, ea;
    @(negedge clk);
    reqt    = pool_ph ? 5 + PL : 9 + PL;
    exp_tap = running && !pool_ph && t < 9;
    exp_rd  = running && pool_ph && t < 4;
    exp_req = running && t >= reqt;
    if (!running) chk_zero("idle");
    else begin
      chk("busy", s.busy, 1);
      chk("tap_valid", s.tap_valid, exp_tap);
      chk("acc_clr", s.acc_clr, exp_tap && t == 0);
      chk("crd", s.crd, exp_rd);
      chk("pool_first", s.pool_first, exp_rd && t == 0);
      chk("wr_req", s.wr_req, exp_req);
      chk("csel", s.csel, exp_rd ? 1 : exp_req ? (pool_ph ? 3 : 1) : 0);
      if (exp_tap) begin
        r   = pix / 64 + t / 3 - 1;
        c   = pix % 64 + t % 3 - 1;
        pad = (r < 0) || (r > 63) || (c < 0) || (c > 63);
        chk("tap_idx", s.tap_idx, t);
        chk("tap_pad", s.tap_pad, pad);
        chk("iaddr", s.iaddr, pad ? 0 : r * 64 + c);
      end
      if (exp_rd) begin
        ea = (2 * (q / 32) + t / 2) * 64 + 2 * (q % 32) + t % 2;
        chk("caddr_rd", s.caddr_rd, ea);
      end
      if (exp_req) chk("wr_addr", s.wr_addr, pool_ph ? q : pix);
    end
    // Ack: random latency while requesting, random noise otherwise.
    if (exp_req) begin
      if (t == reqt)
        wtarget = (!pool_ph && pix == 10) ? 5 :
                  ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 3)) : 0;
      s.wr_ack = (t - reqt == wtarget);
    end else s.wr_ack = 1'($urandom_range(0, 1));
    acked   = exp_req && s.wr_ack;
    s.ready = rdy;
    start   = rdy && !running && !in_done;
    in_done = 0;
    t = acked ? 0 : t + 1;
    if (acked && !pool_ph) begin
      nconv++;
      if (pix == 4095) begin
        if (POOL) begin pool_ph = 1; q = 0; end
        else begin running = 0; in_done = 1; end
      end else pix++;
    end else if (acked) begin
      npool++;
      if (q == 1023) begin running = 0; in_done = 1; end
      else q++;
    end
    if (start) begin
      running = 1; pool_ph = 0; t = 0; pix = 0; q = 0;
    end
  endtask

  initial begin
    int n;
    s.ready  = 1'b0;
    s.wr_ack = 1'b0;
    #1;
    chk_zero("rst");
    #20;
    @(negedge clk);
    reset = 1'b0;
    cyc(0);
    cyc(1);
    // Full pass; a ready pulse at cycle 100 must be ignored.
    n = 0;
    while (running && n < 90000) begin
      cyc(n == 100);
      n++;
    end
    chk("full_timeout", running, 0);
    cyc(0);  // DONE cycle
    cyc(0);
    chk("n_conv_writes", nconv, 4096);
    chk("n_pool_writes", npool, POOL ? 1024 : 0);

    // Second run, reset asserted at tap 4 of pixel 200.
    cyc(1);
    n = 0;
    while (!(running && !pool_ph && pix == 200 && t == 4) && n < 5000) begin
      cyc(0);
      n++;
    end
    chk("reach_pix200", pix, 200);
    @(posedge clk);
    #2;
    chk("pre_rst_tapv", s.tap_valid, 1);
    chk("pre_rst_idx", s.tap_idx, 4);
    reset = 1'b1;
    s.ready = 1'b0;
    s.wr_ack = 1'b0;
    #1;
    chk_zero("midrst");
    running = 0; pool_ph = 0; in_done = 0; t = 0; pix = 0; q = 0;
    @(negedge clk);
    reset = 1'b0;
    cyc(0);
    cyc(1);
    n = 0;
    while (pix < 3 && n < 500) begin
      cyc(0);
      n++;
    end
    chk("restart_pix", pix, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
